// File: rtl/decode_stage_rv32.sv
// RV32I(+M) decode stage: registered decode behind a 2-entry skid buffer so in_ready
// never depends combinationally on out_ready.
module decode_stage_rv32 #(
   parameter int unsigned DATAW = 32,
   parameter bit          EN_M  = 1'b0,
   localparam int unsigned AW   = $clog2(DATAW)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DATAW-1:0] in_ins,
   input  logic [DATAW-1:0] in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DATAW-1:0] out_pc,
   output logic [AW-1:0]    rs1,
   output logic [AW-1:0]    rs2,
   output logic [AW-1:0]    rd,
   output logic             reg_we,
   output logic             link_we,
   output logic             test_branch,
   output logic             always_branch,
   output logic             abs_branch,
   output logic             use_imm,
   output logic             use_pc,
   output logic             ram_we,
   output logic             ram_rd,
   output logic             muldiv,
   output logic             illegal,
   output logic [2:0]       branch_type,
   output logic [3:0]       alu_code,
   output logic [DATAW-1:0] imm
);

   localparam int unsigned BW = 2 * DATAW + 3 * AW + 18;

   localparam logic [6:0] OpImm  = 7'b0010011;
   localparam logic [6:0] OpReg  = 7'b0110011;
   localparam logic [6:0] OpLui  = 7'b0110111;
   localparam logic [6:0] OpAuip = 7'b0010111;
   localparam logic [6:0] OpJal  = 7'b1101111;
   localparam logic [6:0] OpJalr = 7'b1100111;
   localparam logic [6:0] OpBr   = 7'b1100011;
   localparam logic [6:0] OpLoad = 7'b0000011;
   localparam logic [6:0] OpSt   = 7'b0100011;

   localparam logic [3:0] AluAdd = 4'b0000;
   localparam logic [3:0] AluCpy = 4'b1111;

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

   logic [31:0] ins;
   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign ins    = in_ins[31:0];
   assign opcode = ins[6:0];
   assign f3     = ins[14:12];
   assign f7     = ins[31:25];
   assign imm_i  = {{20{ins[31]}}, ins[31:20]};
   assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
   assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   assign imm_u  = {ins[31:12], 12'b0};
   assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

   logic        dec_reg_we, dec_link_we, dec_test_br, dec_always_br, dec_abs_br;
   logic        dec_use_imm, dec_use_pc, dec_ram_we, dec_ram_rd, dec_muldiv, dec_illegal;
   logic [3:0]  dec_alu;
   logic [31:0] dec_imm32;

   always_comb begin
      dec_reg_we    = 1'b0;
      dec_link_we   = 1'b0;
      dec_test_br   = 1'b0;
      dec_always_br = 1'b0;
      dec_abs_br    = 1'b0;
      dec_use_imm   = 1'b0;
      dec_use_pc    = 1'b0;
      dec_ram_we    = 1'b0;
      dec_ram_rd    = 1'b0;
      dec_muldiv    = 1'b0;
      dec_illegal   = 1'b0;
      dec_alu       = AluAdd;
      dec_imm32     = '0;
      case (opcode)
         OpImm: begin
            dec_reg_we  = 1'b1;
            dec_use_imm = 1'b1;
            dec_imm32   = imm_i;
            dec_alu     = {ins[30] & (f3 == 3'd5), f3};
            if ((f3 == 3'd1 && f7 != 7'h00) ||
                (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) dec_illegal = 1'b1;
         end
         OpReg: begin
            dec_reg_we = 1'b1;
            if (EN_M && f7 == 7'h01) begin
               dec_muldiv = 1'b1;
               dec_alu    = {1'b0, f3};
            end else begin
               dec_alu = {ins[30], f3};
               if (f7 != 7'h00 && f7 != 7'h20) dec_illegal = 1'b1;
               if (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) dec_illegal = 1'b1;
            end
         end
         OpLui: begin
            dec_reg_we  = 1'b1;
            dec_use_imm = 1'b1;
            dec_alu     = AluCpy;
            dec_imm32   = imm_u;
         end
         OpAuip: begin
            dec_reg_we  = 1'b1;
            dec_use_imm = 1'b1;
            dec_use_pc  = 1'b1;
            dec_imm32   = imm_u;
         end
         OpJal: begin
            dec_always_br = 1'b1;
            dec_link_we   = 1'b1;
            dec_reg_we    = 1'b1;
            dec_use_imm   = 1'b1;
            dec_alu       = AluCpy;
            dec_imm32     = imm_j;
         end
         OpJalr: begin
            dec_always_br = 1'b1;
            dec_abs_br    = 1'b1;
            dec_link_we   = 1'b1;
            dec_reg_we    = 1'b1;
            dec_use_imm   = 1'b1;
            dec_imm32     = imm_i;
         end
         OpBr: begin
            dec_test_br = 1'b1;
            dec_use_pc  = 1'b1;
            dec_use_imm = 1'b1;
            dec_imm32   = imm_b;
         end
         OpLoad: begin
            dec_reg_we  = 1'b1;
            dec_use_imm = 1'b1;
            dec_ram_rd  = 1'b1;
            dec_imm32   = imm_i;
         end
         OpSt: begin
            dec_ram_we  = 1'b1;
            dec_use_imm = 1'b1;
            dec_imm32   = imm_s;
         end
         default: dec_illegal = 1'b1;
      endcase
      // Illegal bundles still flow down the pipe but must not cause side effects.
      if (dec_illegal) begin
         dec_reg_we    = 1'b0;
         dec_link_we   = 1'b0;
         dec_test_br   = 1'b0;
         dec_always_br = 1'b0;
         dec_abs_br    = 1'b0;
         dec_ram_we    = 1'b0;
         dec_ram_rd    = 1'b0;
         dec_muldiv    = 1'b0;
      end
      if (ins[11:7] == 5'd0) begin
         dec_reg_we  = 1'b0;
         dec_link_we = 1'b0;
      end
   end

   logic [BW-1:0] bundle_d;
   logic [BW-1:0] out_q, skid_q;
   state_e        state_q;
   logic          out_valid_q, in_ready_q;
   logic          in_fire, out_fire;

   assign bundle_d = {in_pc, ins[15 +: AW], ins[20 +: AW], ins[7 +: AW],
                      dec_reg_we, dec_link_we, dec_test_br, dec_always_br, dec_abs_br,
                      dec_use_imm, dec_use_pc, dec_ram_we, dec_ram_rd, dec_muldiv, dec_illegal,
                      f3, dec_alu, DATAW'($signed(dec_imm32))};

   assign in_fire  = in_valid && in_ready_q;
   assign out_fire = out_valid_q && out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StEmpty;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         out_q       <= '0;
         skid_q      <= '0;
      end else if (flush) begin
         state_q     <= StEmpty;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (in_fire) begin
                  out_q       <= bundle_d;
                  state_q     <= StOne;
                  out_valid_q <= 1'b1;
               end
            end
            StOne: begin
               if (in_fire && out_fire) begin
                  out_q <= bundle_d;
               end else if (in_fire) begin
                  skid_q     <= bundle_d;
                  state_q    <= StTwo;
                  in_ready_q <= 1'b0;
               end else if (out_fire) begin
                  state_q     <= StEmpty;
                  out_valid_q <= 1'b0;
               end
            end
            StTwo: begin
               if (out_fire) begin
                  out_q      <= skid_q;
                  state_q    <= StOne;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= StEmpty;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign {out_pc, rs1, rs2, rd, reg_we, link_we, test_branch, always_branch, abs_branch,
           use_imm, use_pc, ram_we, ram_rd, muldiv, illegal, branch_type, alu_code, imm} = out_q;

endmodule

// File: tb/tb_decode_stage_rv32.sv
// Bench for decode_stage_rv32: directed cases plus random traffic on an EN_M=0 and an
// EN_M=1 instance, both checked against a queue-based reference model.
module tb_decode_stage_rv32;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        reg_we;
      logic        link_we;
      logic        test_branch;
      logic        always_branch;
      logic        abs_branch;
      logic        use_imm;
      logic        use_pc;
      logic        ram_we;
      logic        ram_rd;
      logic        muldiv;
      logic        illegal;
      logic [2:0]  branch_type;
      logic [3:0]  alu_code;
      logic [31:0] imm;
   } bundle_t;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [31:0] in_ins, in_pc;
   bundle_t     obs [2];
   logic        rdy [2];
   logic        vld [2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [31:0] pc_w, imm_w;
      logic [4:0]  rs1_w, rs2_w, rd_w;
      logic [2:0]  bt_w;
      logic [3:0]  alu_w;
      logic        f_reg, f_link, f_tb, f_ab, f_abs, f_uimm, f_upc, f_rwe, f_rrd, f_md, f_ill;
      logic        in_ready_w, out_valid_w;

      decode_stage_rv32 #(.DATAW(32), .EN_M(g == 1)) u_dut (
         .clk          (clk),
         .reset        (reset),
         .flush        (flush),
         .in_valid     (in_valid),
         .in_ready     (in_ready_w),
         .in_ins       (in_ins),
         .in_pc        (in_pc),
         .out_valid    (out_valid_w),
         .out_ready    (out_ready),
         .out_pc       (pc_w),
         .rs1          (rs1_w),
         .rs2          (rs2_w),
         .rd           (rd_w),
         .reg_we       (f_reg),
         .link_we      (f_link),
         .test_branch  (f_tb),
         .always_branch(f_ab),
         .abs_branch   (f_abs),
         .use_imm      (f_uimm),
         .use_pc       (f_upc),
         .ram_we       (f_rwe),
         .ram_rd       (f_rrd),
         .muldiv       (f_md),
         .illegal      (f_ill),
         .branch_type  (bt_w),
         .alu_code     (alu_w),
         .imm          (imm_w)
      );

      assign obs[g] = {pc_w, rs1_w, rs2_w, rd_w, f_reg, f_link, f_tb, f_ab, f_abs, f_uimm,
                       f_upc, f_rwe, f_rrd, f_md, f_ill, bt_w, alu_w, imm_w};
      assign rdy[g] = in_ready_w;
      assign vld[g] = out_valid_w;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // Reference decode, written directly from the instruction-set field definitions.
   function automatic bundle_t decode_ref(input logic [31:0] ins, input logic [31:0] pc,
                                          input bit en_m);
      bundle_t b;
      int      f3, f7, sgn;
      bit      bad;
      b = '0;
      b.pc = pc;
      b.rs1 = ins[19:15];
      b.rs2 = ins[24:20];
      b.rd = ins[11:7];
      b.branch_type = ins[14:12];
      f3 = int'(ins[14:12]);
      f7 = int'(ins[31:25]);
      sgn = ins[31] ? 1 : 0;
      bad = 1'b0;
      case (ins[6:0])
         7'h13: begin
            b.reg_we = 1; b.use_imm = 1;
            b.imm = int'(ins[31:20]) - sgn * 4096;
            b.alu_code = 4'((ins[30] && f3 == 5) ? 8 + f3 : f3);
            bad = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
         end
         7'h33: begin
            b.reg_we = 1;
            if (en_m && f7 == 1) begin
               b.muldiv = 1; b.alu_code = 4'(f3);
            end else begin
               b.alu_code = 4'(ins[30] ? 8 + f3 : f3);
               bad = (f7 != 0 && f7 != 32) || (f7 == 32 && f3 != 0 && f3 != 5);
            end
         end
         7'h37: begin
            b.reg_we = 1; b.use_imm = 1; b.alu_code = 15; b.imm = ins & 32'hFFFF_F000;
         end
         7'h17: begin
            b.reg_we = 1; b.use_imm = 1; b.use_pc = 1; b.imm = ins & 32'hFFFF_F000;
         end
         7'h6F: begin
            b.always_branch = 1; b.link_we = 1; b.reg_we = 1; b.use_imm = 1; b.alu_code = 15;
            b.imm = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096
                    - sgn * (1 << 20);
         end
         7'h67: begin
            b.always_branch = 1; b.abs_branch = 1; b.link_we = 1; b.reg_we = 1; b.use_imm = 1;
            b.imm = int'(ins[31:20]) - sgn * 4096;
         end
         7'h63: begin
            b.test_branch = 1; b.use_pc = 1; b.use_imm = 1;
            b.imm = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + int'(ins[7]) * 2048
                    - sgn * 4096;
         end
         7'h03: begin
            b.reg_we = 1; b.use_imm = 1; b.ram_rd = 1;
            b.imm = int'(ins[31:20]) - sgn * 4096;
         end
         7'h23: begin
            b.ram_we = 1; b.use_imm = 1;
            b.imm = int'({ins[31:25], ins[11:7]}) - sgn * 4096;
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         b.illegal = 1;
         {b.reg_we, b.link_we, b.test_branch, b.always_branch, b.abs_branch} = '0;
         {b.ram_we, b.ram_rd, b.muldiv} = '0;
      end
      if (b.rd == 0) begin
         b.reg_we = 0; b.link_we = 0;
      end
      return b;
   endfunction

   bundle_t q0[$];
   bundle_t q1[$];

   // One clock: update the model on the edge, then compare on the falling edge.
   task automatic tick();
      bit acc;
      @(posedge clk);
      if (reset || flush) begin
         q0.delete();
         q1.delete();
      end else begin
         acc = in_valid && q0.size() < 2;
         if (out_ready && q0.size() > 0) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
         end
         if (acc) begin
            q0.push_back(decode_ref(in_ins, in_pc, 1'b0));
            q1.push_back(decode_ref(in_ins, in_pc, 1'b1));
         end
      end
      @(negedge clk);
      check("in_ready_m0", rdy[0], q0.size() < 2);
      check("out_valid_m0", vld[0], q0.size() > 0);
      check("in_ready_m1", rdy[1], q1.size() < 2);
      check("out_valid_m1", vld[1], q1.size() > 0);
      if (q0.size() > 0) check("bundle_m0", obs[0], q0[0]);
      if (q1.size() > 0) check("bundle_m1", obs[1], q1[0]);
   endtask

   function automatic logic [31:0] gen_ins();
      logic [31:0] r;
      logic [6:0]  ops [9];
      int          k;
      ops = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23};
      r = $urandom;
      k = $urandom_range(0, 11);
      if (k < 9) r[6:0] = ops[k];
      else if (k == 10) begin
         r[6:0] = 7'h33;
         case ($urandom_range(0, 2))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: r[31:25] = 7'h01;
         endcase
      end else if (k == 11) begin
         r[6:0] = 7'h13;
         r[14:12] = $urandom_range(0, 1) ? 3'd1 : 3'd5;
         r[31:25] = $urandom_range(0, 1) ? 7'h00 : 7'h20;
      end
      return r;
   endfunction

   task automatic push(input logic [31:0] ins, input logic [31:0] pc);
      in_valid = 1'b1;
      in_ins = ins;
      in_pc = pc;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      in_ins = 32'h0050_0093; in_pc = 32'h40;
      tick();
      tick();
      check("reset_bundle", obs[0], '0);
      reset = 1'b0;
      in_valid = 1'b0;
      tick();
      check("reset_in_ready", rdy[0], 1'b1);

      // addi x1,x0,5
      out_ready = 1'b1;
      push(32'h0050_0093, 32'h100);
      check("addi_valid", vld[0], 1'b1);
      check("addi_rd", obs[0].rd, 5'd1);
      check("addi_imm", obs[0].imm, 32'd5);
      check("addi_reg_we", obs[0].reg_we, 1'b1);
      check("addi_use_imm", obs[0].use_imm, 1'b1);
      check("addi_alu", obs[0].alu_code, 4'd0);

      // jal x1,+8
      push(32'h0080_00EF, 32'h104);
      check("jal_imm", obs[0].imm, 32'd8);
      check("jal_always_br", obs[0].always_branch, 1'b1);
      check("jal_link_we", obs[0].link_we, 1'b1);
      check("jal_reg_we", obs[0].reg_we, 1'b1);
      check("jal_alu", obs[0].alu_code, 4'hF);

      // mul x3,x1,x2
      push(32'h0220_81B3, 32'h108);
      check("mul_m1_muldiv", obs[1].muldiv, 1'b1);
      check("mul_m1_reg_we", obs[1].reg_we, 1'b1);
      check("mul_m0_illegal", obs[0].illegal, 1'b1);
      check("mul_m0_reg_we", obs[0].reg_we, 1'b0);
      tick();

      // Skid buffer fills with out_ready low, third beat refused
      out_ready = 1'b0;
      push(32'h0010_0113, 32'h200);
      push(32'h0020_0193, 32'h204);
      check("skid_full_ready", rdy[0], 1'b0);
      push(32'h0030_0213, 32'h208);
      check("skid_hold_pc", obs[0].pc, 32'h200);
      out_ready = 1'b1;
      tick();
      check("skid_second_pc", obs[0].pc, 32'h204);
      tick();
      check("skid_drained", vld[0], 1'b0);

      // Flush from TWO with a simultaneous input
      out_ready = 1'b0;
      push(32'h0010_0113, 32'h300);
      push(32'h0020_0193, 32'h304);
      flush = 1'b1;
      push(32'h0030_0213, 32'h308);
      flush = 1'b0;
      check("flush_valid", vld[0], 1'b0);
      check("flush_ready", rdy[0], 1'b1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();

      // Reset while holding one bundle
      out_ready = 1'b0;
      push(32'h0080_00EF, 32'h400);
      reset = 1'b1;
      tick();
      check("rst_one_valid", vld[0], 1'b0);
      check("rst_one_bundle", obs[0], '0);
      check("rst_one_bundle_m1", obs[1], '0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 1500; i++) begin
         reset = ($urandom_range(0, 99) == 0);
         flush = ($urandom_range(0, 19) == 0);
         in_valid = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         in_ins = gen_ins();
         in_pc = $urandom & 32'hFFFF_FFFC;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
